iir_filter_mc: RTL and testbench

//  Multichannel direct-form-I IIR filter with parametrised order and fixed-point coefficients.

---
 rtl/iir_filter_mc_pkg.sv | 29 ++
 rtl/iir_filter_mc_mac.sv | 36 +++
 rtl/iir_filter_mc.sv | 219 +++++++++++++++++++++
 tb/tb_iir_filter_mc.sv | 550 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/iir_filter_mc_pkg.sv
// Shared constants, FSM state type and fixed-point helper
// for the multichannel direct-form-I IIR filter.
package iir_filter_mc_pkg;

    localparam int FRAC_BITS_DEF = 10;
    localparam int DQ_W          = 128;

    // Default deemphasis coefficients
    localparam logic [31:0] DEEMPH_B  = 32'h0000_00b2;
    localparam logic [31:0] DEEMPH_A0 = 32'h0000_0000;
    localparam logic [31:0] DEEMPH_A1 = 32'hffff_fd66;

    typedef enum logic [1:0] {
        READ  = 2'd0,
        MAC   = 2'd1,
        WRITE = 2'd2
    } iir_state_t;

    // Divide by 2^frac, rounding toward zero
    function automatic logic signed [DQ_W-1:0] DEQUANTIZE_I(
        input logic signed [DQ_W-1:0] p,
        input int                     frac
    );
        logic signed [DQ_W-1:0] bias;
        bias = p[DQ_W-1] ? ((DQ_W'(1) << frac) - DQ_W'(1)) : '0;
        return (p + bias) >>> frac;
    endfunction

endpackage

// File: rtl/iir_filter_mc_mac.sv
// Multiply, dequantize toward zero and accumulate.
// One product per enabled cycle; clear has priority.
module iir_filter_mc_mac
    import iir_filter_mc_pkg::*;
#(
    parameter int DW = 32,
    parameter int AW = DW + 8,
    parameter int FB = FRAC_BITS_DEF
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 i_clr,
    input  logic                 i_en,
    input  logic signed [DW-1:0] i_coeff,
    input  logic signed [DW-1:0] i_data,
    output logic signed [AW-1:0] o_acc
);

    logic signed [2*DW-1:0] w_prod;
    logic signed [AW-1:0]   w_term;

    assign w_prod = (2*DW)'(i_coeff) * (2*DW)'(i_data);
    assign w_term = AW'(DEQUANTIZE_I(DQ_W'(w_prod), FB));

    // Accumulator register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            o_acc <= '0;
        end else if (i_clr) begin
            o_acc <= '0;
        end else if (i_en) begin
            o_acc <= o_acc + w_term;
        end
    end

endmodule

// File: rtl/iir_filter_mc.sv
// Multichannel DF-I IIR filter, one shared MAC, FIFO-to-FIFO.
// Optional IIR_SAT_EN: clamp output and add sticky sat_seen.
module iir_filter_mc
    import iir_filter_mc_pkg::*;
#(
    parameter int DATA_WIDTH   = 32,
    parameter int TAPS         = 2,
    parameter int NUM_CHANNELS = 1,
    parameter int FRAC_BITS    = FRAC_BITS_DEF,
    parameter logic [0:TAPS-1][DATA_WIDTH-1:0] X_COEFFS =
        {DEEMPH_B, DEEMPH_B},
    parameter logic [0:TAPS-1][DATA_WIDTH-1:0] Y_COEFFS =
        {DEEMPH_A0, DEEMPH_A1},
    localparam int CHW =
        (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         clear_hist,
    input  logic                         x_in_empty,
    input  logic signed [DATA_WIDTH-1:0] x_in,
    output logic                         x_in_rd_en,
    input  logic                         y_out_full,
    output logic signed [DATA_WIDTH-1:0] y_out,
    output logic [CHW-1:0]               y_out_ch,
    output logic                         y_out_wr_en
`ifdef IIR_SAT_EN
    ,
    output logic                         sat_seen
`endif
);

    localparam int AW  = DATA_WIDTH + 8;
    localparam int TCW = $clog2(2*TAPS-1);
    localparam int TIW = $clog2(TAPS);
    localparam int YIW = (TAPS > 2) ? $clog2(TAPS-1) : 1;

    localparam logic [TCW-1:0] TAP_LAST = TCW'(2*TAPS-2);
    localparam logic [TCW-1:0] TAP_Y0   = TCW'(TAPS);
    localparam logic [CHW-1:0] CH_LAST  = CHW'(NUM_CHANNELS-1);

    iir_state_t r_state;
    iir_state_t w_next;

    logic [TCW-1:0] r_tap;
    logic [CHW-1:0] r_ch;

    // x[n-k] at [k]; y[n-1-j] at [j]
    logic signed [DATA_WIDTH-1:0] r_x_hist [NUM_CHANNELS][TAPS];
    logic signed [DATA_WIDTH-1:0] r_y_hist [NUM_CHANNELS][TAPS-1];

    logic [TIW-1:0]               w_xi;
    logic [TIW-1:0]               w_ai;
    logic [YIW-1:0]               w_yi;
    logic signed [DATA_WIDTH-1:0] w_coeff;
    logic signed [DATA_WIDTH-1:0] w_data;
    logic signed [AW-1:0]         w_acc;
    logic signed [DATA_WIDTH-1:0] w_y;

    // Next state and FIFO strobes
    always_comb begin
        w_next      = r_state;
        x_in_rd_en  = 1'b0;
        y_out_wr_en = 1'b0;
        unique case (r_state)
            READ: begin
                if (!x_in_empty) begin
                    x_in_rd_en = 1'b1;
                    w_next     = MAC;
                end
            end
            MAC: begin
                if (r_tap == TAP_LAST) begin
                    w_next = WRITE;
                end
            end
            WRITE: begin
                if (!y_out_full) begin
                    y_out_wr_en = 1'b1;
                    w_next      = READ;
                end
            end
            default: w_next = READ;
        endcase
        if (rst || clear_hist) begin
            x_in_rd_en  = 1'b0;
            y_out_wr_en = 1'b0;
            w_next      = READ;
        end
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= READ;
        end else begin
            r_state <= w_next;
        end
    end

    // Tap operand select: b_k * x[n-k], then a_k * y[n-k]
    always_comb begin
        w_xi    = '0;
        w_ai    = '0;
        w_yi    = '0;
        w_coeff = '0;
        w_data  = '0;
        if (r_tap < TAP_Y0) begin
            w_xi    = TIW'(r_tap);
            w_coeff = X_COEFFS[w_xi];
            w_data  = r_x_hist[r_ch][w_xi];
        end else begin
            w_ai    = TIW'(r_tap - TAP_Y0 + 1'b1);
            w_yi    = YIW'(r_tap - TAP_Y0);
            w_coeff = Y_COEFFS[w_ai];
            w_data  = r_y_hist[r_ch][w_yi];
        end
    end

    iir_filter_mc_mac #(
        .DW (DATA_WIDTH),
        .AW (AW),
        .FB (FRAC_BITS)
    ) u_mac (
        .clk     (clk),
        .rst     (rst),
        .i_clr   (x_in_rd_en | clear_hist),
        .i_en    (r_state == MAC),
        .i_coeff (w_coeff),
        .i_data  (w_data),
        .o_acc   (w_acc)
    );

`ifdef IIR_SAT_EN
    localparam logic signed [AW-1:0] Y_MAX =
        {{(AW-DATA_WIDTH+1){1'b0}}, {(DATA_WIDTH-1){1'b1}}};
    localparam logic signed [AW-1:0] Y_MIN =
        {{(AW-DATA_WIDTH+1){1'b1}}, {(DATA_WIDTH-1){1'b0}}};

    logic w_sat;

    // Clamp the wide sum into the output range
    always_comb begin
        w_sat = 1'b0;
        w_y   = w_acc[DATA_WIDTH-1:0];
        if (w_acc > Y_MAX) begin
            w_sat = 1'b1;
            w_y   = Y_MAX[DATA_WIDTH-1:0];
        end else if (w_acc < Y_MIN) begin
            w_sat = 1'b1;
            w_y   = Y_MIN[DATA_WIDTH-1:0];
        end
    end

    // Sticky saturation flag, set on a clamped push
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sat_seen <= 1'b0;
        end else if (clear_hist) begin
            sat_seen <= 1'b0;
        end else if (y_out_wr_en && w_sat) begin
            sat_seen <= 1'b1;
        end
    end
`else
    logic [AW-DATA_WIDTH-1:0] w_unused_acc_hi;

    assign w_unused_acc_hi = w_acc[AW-1:DATA_WIDTH];
    assign w_y             = w_acc[DATA_WIDTH-1:0];
`endif

    assign y_out    = w_y;
    assign y_out_ch = r_ch;

    // Tap counter, channel counter and per-channel histories
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_tap <= '0;
            r_ch  <= '0;
            for (int c = 0; c < NUM_CHANNELS; c++) begin
                for (int k = 0; k < TAPS; k++) begin
                    r_x_hist[c][k] <= '0;
                end
                for (int k = 0; k < TAPS-1; k++) begin
                    r_y_hist[c][k] <= '0;
                end
            end
        end else if (clear_hist) begin
            r_tap <= '0;
            r_ch  <= '0;
            for (int c = 0; c < NUM_CHANNELS; c++) begin
                for (int k = 0; k < TAPS; k++) begin
                    r_x_hist[c][k] <= '0;
                end
                for (int k = 0; k < TAPS-1; k++) begin
                    r_y_hist[c][k] <= '0;
                end
            end
        end else begin
            if (x_in_rd_en) begin
                r_tap <= '0;
                for (int k = TAPS-1; k > 0; k--) begin
                    r_x_hist[r_ch][k] <= r_x_hist[r_ch][k-1];
                end
                r_x_hist[r_ch][0] <= x_in;
            end else if (r_state == MAC) begin
                r_tap <= r_tap + 1'b1;
            end
            if (y_out_wr_en) begin
                for (int k = TAPS-2; k > 0; k--) begin
                    r_y_hist[r_ch][k] <= r_y_hist[r_ch][k-1];
                end
                r_y_hist[r_ch][0] <= w_y;
                r_ch <= (r_ch == CH_LAST) ? '0 : r_ch + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_iir_filter_mc.sv
// Self-checking bench for iir_filter_mc: three instances
// (deemphasis N=1, deemphasis N=2, DW=16 overflow case).
module tb_iir_filter_mc;

    localparam int ND   = 3;
    localparam int TAPS = 2;

    typedef struct packed {
        logic signed [31:0] y;
        logic               ch;
    } exp_t;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    logic               s_clr   [ND];
    logic               s_empty [ND];
    logic               s_full  [ND];
    logic signed [31:0] s_x     [ND];

    logic               w_rd [ND];
    logic               w_wr [ND];
    logic               w_ch [ND];
    logic signed [31:0] w_y  [ND];

    logic               a_rd, a_wr, a_ch;
    logic               b_rd, b_wr, b_ch;
    logic               c_rd, c_wr, c_ch;
    logic signed [31:0] a_y, b_y;
    logic signed [15:0] c_y;
`ifdef IIR_SAT_EN
    logic sat_a, sat_b, sat_c;
`endif

    int   checks = 0;
    int   errors = 0;
    exp_t sb [$];

    assign w_rd[0] = a_rd;
    assign w_wr[0] = a_wr;
    assign w_ch[0] = a_ch;
    assign w_y[0]  = a_y;
    assign w_rd[1] = b_rd;
    assign w_wr[1] = b_wr;
    assign w_ch[1] = b_ch;
    assign w_y[1]  = b_y;
    assign w_rd[2] = c_rd;
    assign w_wr[2] = c_wr;
    assign w_ch[2] = c_ch;
    assign w_y[2]  = 32'(c_y);

    iir_filter_mc u_a (
        .clk         (clk),
        .rst         (rst),
        .clear_hist  (s_clr[0]),
        .x_in_empty  (s_empty[0]),
        .x_in        (s_x[0]),
        .x_in_rd_en  (a_rd),
        .y_out_full  (s_full[0]),
        .y_out       (a_y),
        .y_out_ch    (a_ch),
        .y_out_wr_en (a_wr)
`ifdef IIR_SAT_EN
        ,
        .sat_seen    (sat_a)
`endif
    );

    iir_filter_mc #(
        .NUM_CHANNELS (2)
    ) u_b (
        .clk         (clk),
        .rst         (rst),
        .clear_hist  (s_clr[1]),
        .x_in_empty  (s_empty[1]),
        .x_in        (s_x[1]),
        .x_in_rd_en  (b_rd),
        .y_out_full  (s_full[1]),
        .y_out       (b_y),
        .y_out_ch    (b_ch),
        .y_out_wr_en (b_wr)
`ifdef IIR_SAT_EN
        ,
        .sat_seen    (sat_b)
`endif
    );

    iir_filter_mc #(
        .DATA_WIDTH (16),
        .X_COEFFS   ({16'd4096, 16'd4096}),
        .Y_COEFFS   ({16'd0, 16'd0})
    ) u_c (
        .clk         (clk),
        .rst         (rst),
        .clear_hist  (s_clr[2]),
        .x_in_empty  (s_empty[2]),
        .x_in        (s_x[2][15:0]),
        .x_in_rd_en  (c_rd),
        .y_out_full  (s_full[2]),
        .y_out       (c_y),
        .y_out_ch    (c_ch),
        .y_out_wr_en (c_wr)
`ifdef IIR_SAT_EN
        ,
        .sat_seen    (sat_c)
`endif
    );

    task automatic pulse_clear(input int d);
        @(negedge clk);
        s_clr[d] = 1'b1;
        @(negedge clk);
        s_clr[d] = 1'b0;
    endtask

    // Offer one sample, wait for its push; lat = rd-to-wr cycles
    task automatic run_sample(
        input  int                 d,
        input  logic signed [31:0] v,
        output logic signed [31:0] y,
        output logic               ch,
        output int                 lat,
        output bit                 ok
    );
        int n;
        ok  = 1'b0;
        y   = '0;
        ch  = 1'b0;
        lat = -1;
        @(negedge clk);
        s_x[d]     = v;
        s_empty[d] = 1'b0;
        #1;
        n = 0;
        while (!w_rd[d] && n < 50) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (!w_rd[d]) begin
            s_empty[d] = 1'b1;
            return;
        end
        @(negedge clk);
        s_empty[d] = 1'b1;
        #1;
        n = 0;
        while (!w_wr[d] && n < 50) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (!w_wr[d]) return;
        y   = w_y[d];
        ch  = w_ch[d];
        lat = n + 1;
        ok  = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst        = 1'b1;
        s_empty[0] = 1'b0;
        @(negedge clk);
        #1;
        checks++;
        if (a_rd !== 1'b0) begin
            errors++;
            $display("FAIL reset_rd got %b expected 0", a_rd);
        end
        checks++;
        if (a_wr !== 1'b0) begin
            errors++;
            $display("FAIL reset_wr got %b expected 0", a_wr);
        end
        checks++;
        if (a_y !== 32'sd0) begin
            errors++;
            $display("FAIL reset_y got %0d expected 0", a_y);
        end
        checks++;
        if (a_ch !== 1'b0) begin
            errors++;
            $display("FAIL reset_ch got %b expected 0", a_ch);
        end
        s_empty[0] = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        checks++;
        if (a_rd !== 1'b0 || a_wr !== 1'b0) begin
            errors++;
            $display("FAIL idle_strobes got rd=%b wr=%b expected 0 0",
                     a_rd, a_wr);
        end
    endtask

    task automatic test_impulse();
        int                 xs [3] = '{1024, 0, 0};
        int                 ys [3] = '{178, 63, -40};
        logic signed [31:0] y;
        logic               ch;
        int                 lat;
        bit                 ok;
        exp_t               e;
        pulse_clear(0);
        for (int i = 0; i < 3; i++) begin
            e.y  = 32'(ys[i]);
            e.ch = 1'b0;
            sb.push_back(e);
            run_sample(0, 32'(xs[i]), y, ch, lat, ok);
            e = sb.pop_front();
            checks++;
            if (!ok) begin
                errors++;
                $display("FAIL impulse_push[%0d] got none expected wr_en", i);
            end else begin
                checks++;
                if (y !== e.y) begin
                    errors++;
                    $display("FAIL impulse_y[%0d] got %0d expected %0d",
                             i, y, e.y);
                end
                checks++;
                if (ch !== e.ch) begin
                    errors++;
                    $display("FAIL impulse_ch[%0d] got %b expected %b",
                             i, ch, e.ch);
                end
                checks++;
                if (lat !== 2*TAPS) begin
                    errors++;
                    $display("FAIL latency[%0d] got %0d expected %0d",
                             i, lat, 2*TAPS);
                end
            end
        end
    endtask

    task automatic test_toward_zero();
        int                 xs [2] = '{-1, 0};
        logic signed [31:0] y;
        logic               ch;
        int                 lat;
        bit                 ok;
        exp_t               e;
        @(negedge clk);
        s_x[0]     = 32'sd5;
        s_empty[0] = 1'b0;
        s_clr[0]   = 1'b1;
        #1;
        checks++;
        if (a_rd !== 1'b0) begin
            errors++;
            $display("FAIL clear_blocks_rd got %b expected 0", a_rd);
        end
        @(negedge clk);
        s_clr[0]   = 1'b0;
        s_empty[0] = 1'b1;
        for (int i = 0; i < 2; i++) begin
            e.y  = 32'sd0;
            e.ch = 1'b0;
            sb.push_back(e);
            run_sample(0, 32'(xs[i]), y, ch, lat, ok);
            e = sb.pop_front();
            checks++;
            if (!ok) begin
                errors++;
                $display("FAIL tz_push[%0d] got none expected wr_en", i);
            end else begin
                checks++;
                if (y !== e.y) begin
                    errors++;
                    $display("FAIL tz_y[%0d] got %0d expected %0d",
                             i, y, e.y);
                end
            end
        end
    endtask

    task automatic test_interleave();
        int                 xs [4] = '{1024, 0, 0, 0};
        int                 ys [4] = '{178, 0, 63, 0};
        logic signed [31:0] y;
        logic               ch;
        int                 lat;
        bit                 ok;
        exp_t               e;
        pulse_clear(1);
        for (int i = 0; i < 4; i++) begin
            e.y  = 32'(ys[i]);
            e.ch = (i % 2 == 1);
            sb.push_back(e);
            run_sample(1, 32'(xs[i]), y, ch, lat, ok);
            e = sb.pop_front();
            checks++;
            if (!ok) begin
                errors++;
                $display("FAIL il_push[%0d] got none expected wr_en", i);
            end else begin
                checks++;
                if (y !== e.y) begin
                    errors++;
                    $display("FAIL il_y[%0d] got %0d expected %0d",
                             i, y, e.y);
                end
                checks++;
                if (ch !== e.ch) begin
                    errors++;
                    $display("FAIL il_ch[%0d] got %b expected %b",
                             i, ch, e.ch);
                end
            end
        end
    endtask

    task automatic test_backpressure();
        logic signed [31:0] y;
        logic               ch;
        int                 lat;
        bit                 ok;
        int                 n;
        exp_t               e;
        pulse_clear(0);
        e.y  = 32'sd178;
        e.ch = 1'b0;
        sb.push_back(e);
        @(negedge clk);
        s_x[0]     = 32'sd1024;
        s_empty[0] = 1'b0;
        s_full[0]  = 1'b1;
        #1;
        n = 0;
        while (!a_rd && n < 50) begin
            @(negedge clk);
            #1;
            n++;
        end
        checks++;
        if (!a_rd) begin
            errors++;
            $display("FAIL bp_read got 0 expected rd_en");
        end
        @(negedge clk);
        s_x[0] = 32'sd0;
        e = sb.pop_front();
        repeat (2*TAPS-1) @(negedge clk);
        for (int i = 0; i < 10; i++) begin
            #1;
            checks++;
            if (a_wr !== 1'b0) begin
                errors++;
                $display("FAIL bp_wr[%0d] got %b expected 0", i, a_wr);
            end
            checks++;
            if (a_rd !== 1'b0) begin
                errors++;
                $display("FAIL bp_rd[%0d] got %b expected 0", i, a_rd);
            end
            checks++;
            if (a_y !== e.y) begin
                errors++;
                $display("FAIL bp_y[%0d] got %0d expected %0d",
                         i, a_y, e.y);
            end
            @(negedge clk);
        end
        s_full[0]  = 1'b0;
        s_empty[0] = 1'b1;
        #1;
        checks++;
        if (a_wr !== 1'b1 || a_y !== e.y || a_ch !== e.ch) begin
            errors++;
            $display("FAIL bp_release got wr=%b y=%0d ch=%b expected 1 %0d %b",
                     a_wr, a_y, a_ch, e.y, e.ch);
        end
        @(negedge clk);
        #1;
        checks++;
        if (a_wr !== 1'b0) begin
            errors++;
            $display("FAIL bp_single_push got %b expected 0", a_wr);
        end
        e.y  = 32'sd63;
        e.ch = 1'b0;
        sb.push_back(e);
        run_sample(0, 32'sd0, y, ch, lat, ok);
        e = sb.pop_front();
        checks++;
        if (!ok || y !== e.y) begin
            errors++;
            $display("FAIL bp_next_y got ok=%b y=%0d expected 1 %0d",
                     ok, y, e.y);
        end
    endtask

    task automatic test_clear_mid_mac();
        logic signed [31:0] y;
        logic               ch;
        int                 lat;
        bit                 ok;
        int                 n;
        exp_t               e;
        @(negedge clk);
        s_x[0]     = 32'sd1024;
        s_empty[0] = 1'b0;
        #1;
        n = 0;
        while (!a_rd && n < 50) begin
            @(negedge clk);
            #1;
            n++;
        end
        @(negedge clk);
        s_empty[0] = 1'b1;
        s_clr[0]   = 1'b1;
        @(negedge clk);
        s_clr[0] = 1'b0;
        for (int i = 0; i < 10; i++) begin
            #1;
            checks++;
            if (a_wr !== 1'b0) begin
                errors++;
                $display("FAIL clr_nowr[%0d] got %b expected 0", i, a_wr);
            end
            @(negedge clk);
        end
        e.y  = 32'sd178;
        e.ch = 1'b0;
        sb.push_back(e);
        run_sample(0, 32'sd1024, y, ch, lat, ok);
        e = sb.pop_front();
        checks++;
        if (!ok || y !== e.y || ch !== e.ch) begin
            errors++;
            $display("FAIL clr_after got ok=%b y=%0d ch=%b expected 1 %0d %b",
                     ok, y, ch, e.y, e.ch);
        end
    endtask

    task automatic test_reset_mid_mac();
        logic signed [31:0] y;
        logic               ch;
        int                 lat;
        bit                 ok;
        int                 n;
        exp_t               e;
        pulse_clear(1);
        run_sample(1, 32'sd1024, y, ch, lat, ok);
        @(negedge clk);
        s_x[1]     = 32'sd500;
        s_empty[1] = 1'b0;
        #1;
        n = 0;
        while (!b_rd && n < 50) begin
            @(negedge clk);
            #1;
            n++;
        end
        @(negedge clk);
        s_empty[1] = 1'b1;
        rst        = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 10; i++) begin
            #1;
            checks++;
            if (b_wr !== 1'b0) begin
                errors++;
                $display("FAIL rst_nowr[%0d] got %b expected 0", i, b_wr);
            end
            @(negedge clk);
        end
        e.y  = 32'sd178;
        e.ch = 1'b0;
        sb.push_back(e);
        run_sample(1, 32'sd1024, y, ch, lat, ok);
        e = sb.pop_front();
        checks++;
        if (!ok || y !== e.y || ch !== e.ch) begin
            errors++;
            $display("FAIL rst_after got ok=%b y=%0d ch=%b expected 1 %0d %b",
                     ok, y, ch, e.y, e.ch);
        end
    endtask

    task automatic test_overflow();
`ifdef IIR_SAT_EN
        int                 ys [2] = '{32767, 32767};
`else
        int                 ys [2] = '{-4, -8};
`endif
        logic signed [31:0] y;
        logic               ch;
        int                 lat;
        bit                 ok;
        exp_t               e;
        pulse_clear(2);
`ifdef IIR_SAT_EN
        checks++;
        if (sat_c !== 1'b0) begin
            errors++;
            $display("FAIL sat_clear got %b expected 0", sat_c);
        end
`endif
        for (int i = 0; i < 2; i++) begin
            e.y  = 32'(ys[i]);
            e.ch = 1'b0;
            sb.push_back(e);
            run_sample(2, 32'sd32767, y, ch, lat, ok);
            e = sb.pop_front();
            checks++;
            if (!ok || y !== e.y) begin
                errors++;
                $display("FAIL ovf_y[%0d] got ok=%b y=%0d expected 1 %0d",
                         i, ok, y, e.y);
            end
        end
`ifdef IIR_SAT_EN
        checks++;
        if (sat_c !== 1'b1) begin
            errors++;
            $display("FAIL sat_seen got %b expected 1", sat_c);
        end
`endif
    endtask

    initial begin
        rst = 1'b1;
        for (int i = 0; i < ND; i++) begin
            s_clr[i]   = 1'b0;
            s_empty[i] = 1'b1;
            s_full[i]  = 1'b0;
            s_x[i]     = '0;
        end
        test_reset();
        test_impulse();
        test_toward_zero();
        test_interleave();
        test_backpressure();
        test_clear_mid_mac();
        test_reset_mid_mac();
        test_overflow();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
